io_sram_ctrl: RTL and testbench

On-chip SRAM slave for the CPU core's external io bus. It consumes the `io_*` master interface that `cpu_top` drives and returns `io_rdata`/`io_ready`. It supports:
- single byte/half/word reads and writes;
- incrementing word bursts of up to 8 beats, with master back-pressure on reads via `read_ready`.

It sits directly downstream of the core in the SoC, behind the address decoder, as the boot/data RAM.

---
 rtl/io_bus_pkg.sv | 60 ++++++
 rtl/io_sram_ctrl_if.sv | 29 ++
 rtl/io_sram_ctrl_sram.sv | 30 +++
 rtl/io_sram_ctrl.sv | 169 ++++++++++++++++
 tb/tb_io_sram_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_pkg.sv
// Shared io-bus definitions: address width, size codes, FSM states, lane helpers.
package io_bus_pkg;

  // Highest bit of the io-bus byte address (32-bit bus).
  localparam int MAX_BIT_POS     = 31;
  localparam int MAX_BURST_BEATS = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Both 10 and 11 mean a full word on the bus.
  function automatic size_e norm_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  // Byte enables for one access; misaligned halves fall back to their aligned lane.
  function automatic logic [3:0] lane_be(input size_e sz, input logic [1:0] lane);
    case (sz)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Right-aligned write data replicated across lanes; byte enables pick the live one.
  function automatic logic [31:0] lane_wdata(input size_e sz, input logic [31:0] wdata);
    case (sz)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0 and zero-extend.
  function automatic logic [31:0] lane_rdata(input size_e sz, input logic [1:0] lane,
                                             input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (sz)
      SZ_BYTE: return {24'h0, sh[7:0]};
      SZ_HALF: return lane[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/io_sram_ctrl_if.sv
// io-bus between the core (master) and the SRAM slave.
// Handshake: the master raises io_read or io_write with address/size/burst info and
// holds them until the final io_ready. io_ready is a one-cycle pulse per completed
// beat. On reads a beat completes only in a cycle where read_ready is high; on writes
// the master presents the next beat's io_wdata the cycle after each io_ready.
interface io_sram_ctrl_if;
  import io_bus_pkg::*;

  logic [MAX_BIT_POS:0] io_addr;
  logic                 io_read;
  logic                 io_write;
  logic                 burst;
  logic [2:0]           burst_size;
  logic                 read_ready;
  logic [31:0]          io_wdata;
  logic [1:0]           io_byte_size;
  logic [31:0]          io_rdata;
  logic                 io_ready;

  modport master (
    output io_addr, io_read, io_write, burst, burst_size, read_ready, io_wdata, io_byte_size,
    input  io_rdata, io_ready
  );

  modport slave (
    input  io_addr, io_read, io_write, burst, burst_size, read_ready, io_wdata, io_byte_size,
    output io_rdata, io_ready
  );
endinterface

// File: rtl/io_sram_ctrl_sram.sv
// Single-port 32-bit SRAM with byte enables and a registered (1-cycle) read.
module sram_1rw #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           en_i,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [3:0]                     be_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-masked write or registered read; output holds while the array is idle.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/io_sram_ctrl.sv
// io-bus SRAM slave: single and burst transactions, read skid buffer, range checks.
module io_sram_ctrl
  import io_bus_pkg::*;
#(
  parameter logic [MAX_BIT_POS:0] ADDR_BASE   = 32'h8000_0000,
  parameter int                   DEPTH_WORDS = 4096
) (
  input  logic          clk,
  input  logic          rst,
  io_sram_ctrl_if.slave bus,
  output state_e        state_o
);
  localparam int            AW      = $clog2(DEPTH_WORDS);
  localparam int            WW      = MAX_BIT_POS - 1;
  localparam int            BW      = $clog2(MAX_BURST_BEATS);
  localparam logic [WW-1:0] DEPTH_W = WW'(DEPTH_WORDS);

  state_e               state_q, state_d;
  logic [WW-1:0]        addr_q;
  logic [BW-1:0]        beats_q;
  size_e                size_q;
  logic [1:0]           lane_q;
  logic                 wr_phase_q, skid_vld_q, ready_q;
  logic [31:0]          skid_q, rdata_q;

  logic [MAX_BIT_POS:0] req_off;
  logic [WW-1:0]        req_word;
  size_e                req_size;
  logic [1:0]           req_lane;
  logic                 req_any, last_beat;
  logic                 sram_en, sram_we;
  logic [WW-1:0]        sram_word;
  logic [3:0]           sram_be;
  logic [31:0]          sram_wdata, sram_rdata, beat_data;

  // Word indices past the array (including wrapped addresses below the base) are dead.
  function automatic logic in_range(input logic [WW-1:0] w);
    return w < DEPTH_W;
  endfunction

  assign req_off   = bus.io_addr - ADDR_BASE;
  assign req_word  = req_off[MAX_BIT_POS:2];
  assign req_size  = bus.burst ? SZ_WORD : norm_size(bus.io_byte_size);
  assign req_lane  = bus.burst ? 2'b00 : req_off[1:0];
  assign req_any   = bus.io_read | bus.io_write;
  assign last_beat = (beats_q == '0);

  // Current read beat: skid copy if stalled earlier, else fresh SRAM data (0 if out of range).
  assign beat_data = skid_vld_q ? skid_q
                   : (in_range(addr_q) ? lane_rdata(size_q, lane_q, sram_rdata) : 32'h0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; read wins when both request lines are high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.io_read)       state_d = ST_RD;
        else if (bus.io_write) state_d = ST_WR;
      end
      ST_RD:   if (bus.read_ready && last_beat) state_d = ST_DONE;
      ST_WR:   if (!wr_phase_q && last_beat)    state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // SRAM port control: issue the first access from IDLE, the next read on each consumed beat.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_word  = addr_q;
    sram_be    = 4'b0000;
    sram_wdata = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          sram_word = req_word;
          sram_en   = in_range(req_word);
          if (!bus.io_read) begin
            sram_we    = 1'b1;
            sram_be    = lane_be(req_size, req_lane);
            sram_wdata = lane_wdata(req_size, bus.io_wdata);
          end
        end
      end
      ST_RD: begin
        if (bus.read_ready && !last_beat) begin
          sram_word = addr_q + WW'(1);
          sram_en   = in_range(sram_word);
        end
      end
      ST_WR: begin
        if (wr_phase_q) begin
          sram_en    = in_range(addr_q);
          sram_we    = 1'b1;
          sram_be    = lane_be(size_q, lane_q);
          sram_wdata = lane_wdata(size_q, bus.io_wdata);
        end
      end
      default: ;
    endcase
  end

  // Transaction context, beat counter, skid buffer and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q    <= 1'b0;
      rdata_q    <= 32'h0;
      skid_vld_q <= 1'b0;
      wr_phase_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            addr_q     <= req_word;
            beats_q    <= bus.burst ? bus.burst_size : '0;
            size_q     <= req_size;
            lane_q     <= req_lane;
            skid_vld_q <= 1'b0;
            wr_phase_q <= 1'b0;
          end
        end
        ST_RD: begin
          if (bus.read_ready) begin
            rdata_q    <= beat_data;
            ready_q    <= 1'b1;
            skid_vld_q <= 1'b0;
            addr_q     <= addr_q + WW'(1);
            beats_q    <= beats_q - BW'(1);
          end else if (!skid_vld_q) begin
            skid_q     <= beat_data;
            skid_vld_q <= 1'b1;
          end
        end
        ST_WR: begin
          if (!wr_phase_q) begin
            ready_q    <= 1'b1;
            wr_phase_q <= 1'b1;
            addr_q     <= addr_q + WW'(1);
            beats_q    <= beats_q - BW'(1);
          end else begin
            wr_phase_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  sram_1rw #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk     (clk),
    .en_i    (sram_en),
    .we_i    (sram_we),
    .addr_i  (sram_word[AW-1:0]),
    .be_i    (sram_be),
    .wdata_i (sram_wdata),
    .rdata_o (sram_rdata)
  );

  assign bus.io_rdata = rdata_q;
  assign bus.io_ready = ready_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_io_sram_ctrl.sv
// Directed plus randomized bench for io_sram_ctrl against a byte-addressed memory model.
module tb_io_sram_ctrl;
  import io_bus_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  logic   clk, rst;
  state_e state;
  int     total = 0;
  int     bad   = 0;

  logic [7:0]  mb [int unsigned];
  logic [31:0] exp_q [$];

  io_sram_ctrl_if bus();

  io_sram_ctrl #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: little-endian byte memory
  function automatic bit model_in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off >> 2) < 32'(DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] off;
    off = a - BASE;
    if (!model_in_range(a)) return 32'h0;
    case (sz)
      2'b00:   return {24'h0, mb[off]};
      2'b01:   begin off[0] = 1'b0; return {16'h0, mb[off+1], mb[off]}; end
      default: begin off[1:0] = 2'b00; return {mb[off+3], mb[off+2], mb[off+1], mb[off]}; end
    endcase
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [1:0] sz,
                                      input logic [31:0] d);
    logic [31:0] off;
    off = a - BASE;
    if (!model_in_range(a)) return;
    case (sz)
      2'b00: mb[off] = d[7:0];
      2'b01: begin off[0] = 1'b0; mb[off] = d[7:0]; mb[off+1] = d[15:8]; end
      default: begin
        off[1:0] = 2'b00;
        for (int i = 0; i < 4; i++) mb[off + 32'(i)] = d[8*i +: 8];
      end
    endcase
  endfunction

  function automatic int stalls_upto(input logic [7:0] m, input int k);
    int n = 0;
    for (int i = 0; i <= k; i++) if (m[i]) n++;
    return n;
  endfunction

  // driver: read transaction; stall bit k holds read_ready low once before beat k
  task automatic rd(input logic [31:0] a, input logic [1:0] sz, input bit bst, input int nb,
                    input logic [7:0] stall, input bit with_wr, input string tag,
                    output logic [31:0] last);
    int beat, cyc;
    bit stalled;
    logic [31:0] e;
    for (int k = 0; k < nb; k++)
      exp_q.push_back(bst ? model_read({a[31:2], 2'b00} + 32'(4*k), 2'b10) : model_read(a, sz));
    @(negedge clk);
    bus.io_addr = a; bus.io_byte_size = sz; bus.burst = bst; bus.burst_size = 3'(nb - 1);
    bus.io_read = 1'b1; bus.io_write = with_wr; bus.io_wdata = 32'h5A5A_5A5A; bus.read_ready = 1'b1;
    @(posedge clk);
    beat = 0; cyc = 0; stalled = 1'b0; last = 32'h0;
    while (beat < nb && cyc < 64) begin
      @(negedge clk);
      if (stall[beat[2:0]] && !stalled) begin
        bus.read_ready = 1'b0;
        stalled = 1'b1;
      end else begin
        bus.read_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (bus.io_ready) begin
        e = exp_q.pop_front();
        check({tag, "_data"}, bus.io_rdata, e);
        check({tag, "_cyc"}, 32'(cyc), 32'(beat + 1 + stalls_upto(stall, beat)));
        last = bus.io_rdata;
        beat++;
        stalled = 1'b0;
      end
    end
    if (beat < nb) check({tag, "_timeout"}, 32'(beat), 32'(nb));
    exp_q.delete();
    bus.io_read = 1'b0; bus.io_write = 1'b0; bus.read_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'(state), 32'(ST_IDLE));
    check({tag, "_hold"}, bus.io_rdata, last);
  endtask

  // driver: write transaction; next beat's data goes out right after each io_ready
  task automatic wr(input logic [31:0] a, input logic [1:0] sz, input bit bst, input int nb,
                    input logic [31:0] d [8], input string tag);
    int beat, cyc;
    @(negedge clk);
    bus.io_addr = a; bus.io_byte_size = sz; bus.burst = bst; bus.burst_size = 3'(nb - 1);
    bus.io_write = 1'b1; bus.io_read = 1'b0; bus.io_wdata = d[0]; bus.read_ready = 1'b1;
    @(posedge clk);
    beat = 0; cyc = 0;
    while (beat < nb && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.io_ready) begin
        check({tag, "_cyc"}, 32'(cyc), 32'(2*beat + 1));
        beat++;
        if (beat < nb) bus.io_wdata = d[beat];
      end
    end
    if (beat < nb) check({tag, "_timeout"}, 32'(beat), 32'(nb));
    for (int k = 0; k < nb; k++) begin
      if (bst) model_write({a[31:2], 2'b00} + 32'(4*k), 2'b10, d[k]);
      else     model_write(a, sz, d[0]);
    end
    bus.io_write = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'(state), 32'(ST_IDLE));
    check({tag, "_noready"}, 32'(bus.io_ready), 32'h0);
  endtask

  initial begin
    logic [31:0] wd [8];
    logic [31:0] last, a, off;
    int seen, cyc, op, nb, w0;
    logic [1:0] sz;

    rst = 1'b1;
    bus.io_addr = '0; bus.io_read = 1'b0; bus.io_write = 1'b0; bus.burst = 1'b0;
    bus.burst_size = '0; bus.read_ready = 1'b1; bus.io_wdata = '0; bus.io_byte_size = '0;
    for (int i = 0; i < 8; i++) wd[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.io_ready), 32'h0);
    check("rst_rdata", bus.io_rdata, 32'h0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // word write then byte read of lane 1
    wd[0] = 32'hDEAD_BEEF;
    wr(BASE + 32'd8, 2'b10, 1'b0, 1, wd, "w_word");
    rd(BASE + 32'd9, 2'b00, 1'b0, 1, 8'h00, 1'b0, "r_byte", last);
    check("byte_lane", last, 32'h0000_00BE);

    // half write into upper lane of an existing word
    wd[0] = 32'hAABB_CCDD;
    wr(BASE, 2'b10, 1'b0, 1, wd, "w_base");
    wd[0] = 32'h0000_1234;
    wr(BASE + 32'd2, 2'b01, 1'b0, 1, wd, "w_half");
    rd(BASE, 2'b11, 1'b0, 1, 8'h00, 1'b0, "r_merge", last);
    check("half_merge", last, 32'h1234_CCDD);

    // preload 0..7, then 8-beat burst stalled before beats 3 and 6
    for (int k = 0; k < 8; k++) begin
      wd[0] = 32'(k);
      wr(BASE + 32'(4*k), 2'b10, 1'b0, 1, wd, "w_pre");
    end
    rd(BASE, 2'b10, 1'b1, 8, 8'b0010_0100, 1'b0, "r_burst_bp", last);
    check("burst_last", last, 32'd7);

    // 4-beat write burst and readback
    for (int k = 0; k < 4; k++) wd[k] = 32'hA0 + 32'(k);
    wr(BASE + 32'h10, 2'b10, 1'b1, 4, wd, "w_burst");
    rd(BASE + 32'h10, 2'b10, 1'b1, 4, 8'h00, 1'b0, "r_wburst", last);

    // out of range: read returns 0, write must not alias onto word 0
    rd(BASE + 32'(4*DEPTH), 2'b10, 1'b0, 1, 8'h00, 1'b0, "r_oor", last);
    wd[0] = 32'h5555_5555;
    wr(BASE + 32'(4*DEPTH), 2'b10, 1'b0, 1, wd, "w_oor");
    rd(BASE, 2'b10, 1'b0, 1, 8'h00, 1'b0, "r_noalias", last);
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222;
    wr(BASE + 32'(4*(DEPTH-2)), 2'b10, 1'b1, 2, wd, "w_top");
    rd(BASE + 32'(4*(DEPTH-2)), 2'b10, 1'b1, 4, 8'h00, 1'b0, "r_cross", last);
    check("cross_zero", last, 32'h0);

    // read and write together: read only, memory untouched
    wd[0] = 32'hCAFE_F00D;
    wr(BASE + 32'h20, 2'b10, 1'b0, 1, wd, "w_prio");
    rd(BASE + 32'h20, 2'b10, 1'b0, 1, 8'h00, 1'b1, "r_prio", last);
    rd(BASE + 32'h20, 2'b10, 1'b0, 1, 8'h00, 1'b0, "r_prio_after", last);
    check("prio_keep", last, 32'hCAFE_F00D);

    // reset during beat 2 of an 8-beat read
    @(negedge clk);
    bus.io_addr = BASE; bus.burst = 1'b1; bus.burst_size = 3'd7; bus.io_byte_size = 2'b10;
    bus.io_read = 1'b1; bus.read_ready = 1'b1;
    seen = 0; cyc = 0;
    while (seen < 2 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.io_ready) seen++;
    end
    check("rmb_seen", 32'(seen), 32'd2);
    rst = 1'b1;
    bus.io_read = 1'b0;
    @(posedge clk); #1;
    check("rmb_ready", 32'(bus.io_ready), 32'h0);
    check("rmb_state", 32'(state), 32'(ST_IDLE));
    check("rmb_rdata", bus.io_rdata, 32'h0);
    rst = 1'b0;
    rd(BASE + 32'd12, 2'b10, 1'b0, 1, 8'h00, 1'b0, "r_after_rst", last);
    check("preserved", last, 32'd3);

    // randomized traffic over a fully initialised 32-word window
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) wd[k] = $urandom;
      wr(BASE + 32'h200 + 32'(32*b), 2'b10, 1'b1, 8, wd, "rnd_wburst");
    end
    for (int i = 0; i < 30; i++) begin
      op  = $urandom_range(0, 2);
      off = 32'($urandom_range(0, 127));
      a   = BASE + 32'h200 + off;
      sz  = 2'($urandom_range(0, 3));
      case (op)
        0: begin
          wd[0] = $urandom;
          wr(a, sz, 1'b0, 1, wd, "rnd_w");
        end
        1: rd(a, sz, 1'b0, 1, 8'($urandom_range(0, 1)), 1'b0, "rnd_r", last);
        default: begin
          nb = $urandom_range(1, 8);
          w0 = $urandom_range(0, 32 - nb);
          rd(BASE + 32'h200 + 32'(4*w0) + 32'($urandom_range(0, 3)), 2'b10, 1'b1, nb,
             8'($urandom_range(0, 255)), 1'b0, "rnd_rburst", last);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
